display_buffer_sink: RTL and testbench
======================================

Name: display_buffer_sink

Overview:
- Receiving end of the Nios display-buffer PIO interface (`display_buffer_addr_export`, `display_buffer_data_export`, `display_buffer_ctrl_export`).
- Decodes edges on the control byte into three operations: buffer write, back-buffer clear, and frame-synchronised buffer swap.
- Holds a double-buffered pixel RAM.
- Serves the front buffer to the LED tile scanner through a registered read port.

Parameters:
- ADDR_W, 11, word address width; bank depth = 2**ADDR_W.
- DATA_W, 32, pixel word width.
- CTRL_W, 8, control byte width.

Ports:
- clk_clk  in  1  system clock; all logic on its rising edge.
- reset_reset  in  1  asynchronous, active-high reset.
- display_buffer_addr_export  in  ADDR_W  write address from PIO.
- display_buffer_data_export  in  DATA_W  write data from PIO.
- display_buffer_ctrl_export  in  CTRL_W  control byte from PIO.
- frame_start  in  1  one-cycle pulse from scanner at start of each frame.
- rd_addr  in  ADDR_W  scanner read address.
- rd_data  out  DATA_W  front-bank word, one cycle after rd_addr.
- front_sel  out  1  bank currently displayed.
- busy  out  1  high in CLEAR or SWAP_WAIT (fed back to a PIO input).
- overrun  out  1  sticky: a command edge was dropped.

Behaviour:
- Clock/reset: one clock domain, `clk_clk`; reset `reset_reset` is asynchronous, active-high.
- Control bits:
  - ctrl[0] WR, ctrl[1] SWAP, ctrl[2] CLEAR, ctrl[3] OVR_ACK.
  - ctrl[7:4] ignored.
- Input pipeline and edge detect:
  - addr/data/ctrl are registered once (stage s1); ctrl is registered again (s2).
  - edge[i] = s1[i] & ~s2[i].
  - The write uses the s1 addr/data.
  - Latency: ctrl[0] rising before clock edge N, RAM written at edge N+1, readable via rd_addr from edge N+2 if that bank is front.
- Reset:
  - state=IDLE, front_sel=0, busy=0, overrun=0, s1/s2=0, clear counter=0, rd_data=0.
  - RAM contents are not reset.
  - A ctrl bit held high across reset release produces exactly one edge; firmware zeroes ctrl before release.
- Banks:
  - Two banks of 2**ADDR_W words.
  - Writes and clears always target back bank = ~front_sel.
  - Reads always target front_sel.
- FSM IDLE:
  - WR edge: back[s1_addr] <= s1_data.
  - CLEAR edge: counter <= 0, go to CLEAR.
  - Else SWAP edge: go to SWAP_WAIT.
  - CLEAR and SWAP edges in the same cycle: CLEAR wins, SWAP dropped, overrun <= 1.
  - A WR edge coincident with CLEAR/SWAP is still performed; in the CLEAR case it is subsequently overwritten.
- FSM CLEAR:
  - Each cycle writes 0 to back[counter] and increments counter.
  - After writing address 2**ADDR_W-1, return to IDLE.
  - busy is high for exactly 2**ADDR_W cycles.
- FSM SWAP_WAIT:
  - Wait for frame_start; on it, front_sel toggles and state goes to IDLE.
  - A frame_start in the same cycle as the SWAP edge (IDLE) is not used; the next one is.
- Drops: WR/SWAP/CLEAR edges arriving in CLEAR or SWAP_WAIT are discarded and set overrun.
- OVR_ACK edge clears overrun. If OVR_ACK and a dropping edge occur in the same cycle, overrun stays 1 (set wins).
- Read port:
  - rd_data <= front[rd_addr] each cycle.
  - The bank is chosen by the front_sel value present in the cycle rd_addr is sampled. The first read after a toggle therefore returns the new bank.
- Address arithmetic: clear counter is ADDR_W+1 bits; the MSB set means done, so no wrap.
- Reset mid-CLEAR or mid-SWAP_WAIT: abort immediately to IDLE. The bank is partially cleared and front_sel reverts to 0.

Decomposition:
- Package display_buffer_pkg:
  - Ctrl bit index constants (CTRL_WR=0, CTRL_SWAP=1, CTRL_CLEAR=2, CTRL_OVR_ACK=3).
  - State enum {IDLE, CLEAR, SWAP_WAIT}.
- One sub-module, dp_bank_ram:
  - Simple dual-port RAM, 2*2**ADDR_W x DATA_W.
  - One write port, one registered read port.
  - Bank select is the address MSB; must infer M9K.

Test Plan:
- Write and swap: ctrl=0 after reset; addr=0x005, data=0xDEADBEEF, ctrl 0->1; then SWAP rise; pulse frame_start -> front_sel=1, rd_addr=0x005 gives 0xDEADBEEF next cycle.
- Back-bank isolation: with front_sel=1, write 0x12345678 to addr 0x7FF -> rd_addr=0x7FF still returns old front data until next swap+frame_start.
- Clear: CLEAR rise -> busy high exactly 2048 cycles; after swap, reads of 0x000, 0x400, 0x7FF return 0.
- Overrun: WR rise during CLEAR -> write discarded, overrun=1; OVR_ACK rise -> overrun=0; simultaneous CLEAR+SWAP rise in IDLE -> CLEAR runs, overrun=1, front_sel unchanged.
- Swap timing: SWAP rise in same cycle as frame_start -> front_sel unchanged; toggles on the following frame_start pulse only.
- Reset mid-clear: assert reset_reset at clear count 100 -> outputs immediately busy=0, front_sel=0, overrun=0; no further RAM writes.

Source files
------------

// File: rtl/display_buffer_pkg.sv
// Shared definitions for the display-buffer sink.
//   - Bit positions of the commands carried on the PIO control byte.
//   - Controller state encoding.
package display_buffer_pkg;

  // Command bits within the control byte; higher bits are reserved.
  localparam int CTRL_WR      = 0;
  localparam int CTRL_SWAP    = 1;
  localparam int CTRL_CLEAR   = 2;
  localparam int CTRL_OVR_ACK = 3;
  localparam int CTRL_USED    = 4;  // number of meaningful low-order bits

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SWAP_WAIT
  } state_t;

endpackage

// File: rtl/dp_bank_ram.sv
// Simple dual-port RAM holding both pixel banks; the bank is the address MSB.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - {bank, word} write address
//   wdata  - write data
//   raddr  - {bank, word} read address
//   rdata  - registered read data, valid one cycle after raddr
module dp_bank_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W:0]   raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**(ADDR_W+1)];

  // NOTE: the array and its output register carry no reset; a reset term
  // would stop the tools mapping this onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/display_buffer_sink.sv
// Receiving end of the Nios display-buffer PIO interface. Rising edges on the
// control byte request a back-bank write, a back-bank clear, or a buffer swap
// that takes effect at the next frame start. The front bank is served to the
// LED tile scanner through a registered read port.
// Ports:
//   clk_clk, reset_reset          - clock, asynchronous active-high reset
//   display_buffer_addr_export    - PIO write address
//   display_buffer_data_export    - PIO write data
//   display_buffer_ctrl_export    - PIO control byte (WR/SWAP/CLEAR/OVR_ACK)
//   frame_start                   - scanner start-of-frame pulse
//   rd_addr / rd_data             - scanner read port, one cycle latency
//   front_sel                     - bank currently displayed
//   busy                          - clear or swap in progress
//   overrun                       - sticky: a command edge was dropped
module display_buffer_sink
  import display_buffer_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] display_buffer_addr_export,
  input  logic [DATA_W-1:0] display_buffer_data_export,
  input  logic [CTRL_W-1:0] display_buffer_ctrl_export,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              front_sel,
  output logic              busy,
  output logic              overrun
);

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      s1_addr;
  logic [DATA_W-1:0]      s1_data;
  logic [CTRL_USED-1:0]   s1_ctrl, s2_ctrl, ctrl_edge;
  logic [ADDR_W:0]        clr_cnt, clr_cnt_inc;
  logic                   cnt_load, cnt_inc, ovr_set, toggle, any_cmd;
  logic                   ram_we;
  logic [ADDR_W:0]        ram_waddr;
  logic [DATA_W-1:0]      ram_wdata, ram_q;
  logic                   rd_valid;
  logic                   ctrl_unused;

  // Reserved control bits carry no meaning.
  assign ctrl_unused = ^display_buffer_ctrl_export[CTRL_W-1:CTRL_USED];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      s1_addr <= '0;
      s1_data <= '0;
      s1_ctrl <= '0;
      s2_ctrl <= '0;
    end else begin
      s1_addr <= display_buffer_addr_export;
      s1_data <= display_buffer_data_export;
      s1_ctrl <= display_buffer_ctrl_export[CTRL_USED-1:0];
      s2_ctrl <= s1_ctrl;
    end
  end

  assign ctrl_edge   = s1_ctrl & ~s2_ctrl;
  assign any_cmd     = ctrl_edge[CTRL_WR] | ctrl_edge[CTRL_SWAP] | ctrl_edge[CTRL_CLEAR];
  // Extra MSB flags completion of the last word, so the counter never wraps.
  assign clr_cnt_inc = clr_cnt + 1'b1;

  // NOTE: every output of this block is given a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_waddr = {~front_sel, s1_addr};
    ram_wdata = s1_data;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    ovr_set   = 1'b0;
    toggle    = 1'b0;
    unique case (state)
      IDLE: begin
        ram_we = ctrl_edge[CTRL_WR];
        if (ctrl_edge[CTRL_CLEAR]) begin
          state_nxt = CLEAR;
          cnt_load  = 1'b1;
          ovr_set   = ctrl_edge[CTRL_SWAP];  // clear wins, swap is lost
        end else if (ctrl_edge[CTRL_SWAP]) begin
          state_nxt = SWAP_WAIT;
        end
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = {~front_sel, clr_cnt[ADDR_W-1:0]};
        ram_wdata = '0;
        cnt_inc   = 1'b1;
        ovr_set   = any_cmd;
        if (clr_cnt_inc[ADDR_W]) begin
          state_nxt = IDLE;
        end
      end
      SWAP_WAIT: begin
        ovr_set = any_cmd;
        if (frame_start) begin
          toggle    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state     <= IDLE;
      front_sel <= 1'b0;
      overrun   <= 1'b0;
      clr_cnt   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      front_sel <= front_sel ^ toggle;
      rd_valid  <= 1'b1;
      if (ovr_set) begin
        overrun <= 1'b1;                     // a drop outranks an acknowledge
      end else if (ctrl_edge[CTRL_OVR_ACK]) begin
        overrun <= 1'b0;
      end
      if (cnt_load) begin
        clr_cnt <= '0;
      end else if (cnt_inc) begin
        clr_cnt <= clr_cnt_inc;
      end
    end
  end

  assign busy = (state != IDLE);

  dp_bank_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr ({front_sel, rd_addr}),
    .rdata (ram_q)
  );

  // The RAM output register cannot be reset, so hold rd_data at zero until
  // the first read after reset has landed.
  assign rd_data = rd_valid ? ram_q : '0;

endmodule

// File: tb/tb_display_buffer_sink.sv
// Self-checking bench for display_buffer_sink. A transaction-level model holds
// both banks as plain arrays plus the displayed bank and the overrun flag.
module tb_display_buffer_sink;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int CW    = 8;
  localparam int DEPTH = 2**AW;

  localparam logic [CW-1:0] C_WR    = 8'h01;
  localparam logic [CW-1:0] C_SWAP  = 8'h02;
  localparam logic [CW-1:0] C_CLEAR = 8'h04;
  localparam logic [CW-1:0] C_ACK   = 8'h08;

  logic          clk_clk = 1'b0;
  logic          reset_reset = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0;
  logic [CW-1:0] ctrl = '0;
  logic          frame_start = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          front_sel, busy, overrun;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_bank [2][DEPTH];
  bit            m_front = 1'b0;
  bit            m_ovr   = 1'b0;

  display_buffer_sink #(.ADDR_W(AW), .DATA_W(DW), .CTRL_W(CW)) dut (
    .clk_clk                    (clk_clk),
    .reset_reset                (reset_reset),
    .display_buffer_addr_export (addr),
    .display_buffer_data_export (data),
    .display_buffer_ctrl_export (ctrl),
    .frame_start                (frame_start),
    .rd_addr                    (rd_addr),
    .rd_data                    (rd_data),
    .front_sel                  (front_sel),
    .busy                       (busy),
    .overrun                    (overrun)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int back_bank();
    return m_front ? 0 : 1;
  endfunction

  // One full clock, ending on the falling edge where outputs are sampled.
  task automatic tick();
    @(posedge clk_clk);
    @(negedge clk_clk);
  endtask

  // Raise the given control bits for one cycle, then give the command a cycle
  // to take effect.
  task automatic pulse_ctrl(input logic [CW-1:0] mask);
    ctrl = mask;
    tick();
    ctrl = '0;
    tick();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr = a;
    data = d;
    pulse_ctrl(C_WR);
    m_bank[back_bank()][a] = d;
  endtask

  task automatic check_read(input string tag, input logic [AW-1:0] a);
    rd_addr = a;
    tick();
    check(tag, rd_data, m_bank[m_front][a]);
  endtask

  // Counts busy cycles until idle, with a bounded wait.
  task automatic wait_idle(input string tag, output int n);
    n = busy ? 1 : 0;
    for (int i = 0; i < 5000; i++) begin
      if (!busy) break;
      tick();
      if (busy) n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic model_clear_back();
    for (int i = 0; i < DEPTH; i++) m_bank[back_bank()][i] = '0;
  endtask

  task automatic do_clear(input string tag);
    int n;
    pulse_ctrl(C_CLEAR);
    wait_idle({tag, "_done"}, n);
    check({tag, "_busy_cycles"}, 32'(n), 32'(DEPTH));
    model_clear_back();
  endtask

  task automatic do_swap(input string tag);
    pulse_ctrl(C_SWAP);
    check({tag, "_busy_wait"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_front_hold"}, 32'(front_sel), 32'(m_front));
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_front = !m_front;
    check({tag, "_front"}, 32'(front_sel), 32'(m_front));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] wq [$];
    logic [AW-1:0] a;
    int            n;

    // Reset state.
    #12;
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_front", 32'(front_sel), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    tick();

    // Bring both banks to a known (zero) state; also times busy.
    do_clear("clear_b1");
    check("clear_b1_ovr", 32'(overrun), 32'd0);
    do_swap("swap1");
    check_read("clr_rd_000", 11'h000);
    check_read("clr_rd_400", 11'h400);
    check_read("clr_rd_7ff", 11'h7FF);
    do_clear("clear_b0");

    // Write and swap.
    do_write(11'h005, 32'hDEADBEEF);
    check_read("iso_005", 11'h005);
    do_swap("swap2");
    check_read("ws_005", 11'h005);

    // Random writes into the back bank never disturb the displayed bank.
    for (int i = 0; i < 24; i++) begin
      a = AW'($urandom_range(0, DEPTH - 1));
      do_write(a, $urandom);
      wq.push_back(a);
      check_read("iso_rand", a);
    end
    do_swap("swap3");
    foreach (wq[i]) check_read("post_swap_rand", wq[i]);

    // Back-bank isolation at the top address while bank 1 is displayed.
    do_write(11'h7FF, 32'h12345678);
    check_read("iso_7ff", 11'h7FF);

    // A frame_start coincident with the SWAP edge is ignored.
    ctrl = C_SWAP;
    tick();
    ctrl = '0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("coinc_busy", 32'(busy), 32'd1);
    check("coinc_front", 32'(front_sel), 32'(m_front));
    repeat (3) tick();
    check("coinc_front_hold", 32'(front_sel), 32'(m_front));
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_front = !m_front;
    check("coinc_toggle", 32'(front_sel), 32'(m_front));
    check_read("coinc_7ff", 11'h7FF);

    // A write during CLEAR is dropped and flags overrun.
    pulse_ctrl(C_CLEAR);
    addr = 11'h123;
    data = $urandom | 32'h1;
    pulse_ctrl(C_WR);
    m_ovr = 1'b1;
    check("drop_wr_ovr", 32'(overrun), 32'(m_ovr));
    wait_idle("drop_clear_done", n);
    model_clear_back();
    do_swap("swap4");
    check_read("drop_wr_123", 11'h123);
    check("ovr_sticky", 32'(overrun), 32'(m_ovr));
    pulse_ctrl(C_ACK);
    m_ovr = 1'b0;
    check("ovr_ack", 32'(overrun), 32'(m_ovr));

    // In SWAP_WAIT, a dropped write in the same cycle as OVR_ACK keeps overrun set.
    pulse_ctrl(C_SWAP);
    check("sw_busy", 32'(busy), 32'd1);
    addr = 11'h0AA;
    data = 32'hA5A5A5A5;
    pulse_ctrl(C_WR | C_ACK);
    m_ovr = 1'b1;
    check("set_beats_ack", 32'(overrun), 32'(m_ovr));
    pulse_ctrl(C_ACK);
    m_ovr = 1'b0;
    check("ack_in_wait", 32'(overrun), 32'(m_ovr));
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_front = !m_front;
    check("sw_toggle", 32'(front_sel), 32'(m_front));
    check_read("sw_drop_0aa", 11'h0AA);

    // CLEAR and SWAP together: clear runs, swap is lost.
    pulse_ctrl(C_CLEAR | C_SWAP);
    wait_idle("cs_done", n);
    check("cs_busy_cycles", 32'(n), 32'(DEPTH));
    model_clear_back();
    m_ovr = 1'b1;
    check("cs_ovr", 32'(overrun), 32'(m_ovr));
    check("cs_front", 32'(front_sel), 32'(m_front));

    // Reset in the middle of a clear of bank 0.
    if (m_front == 1'b0) do_swap("swap5");
    for (int i = 96; i < 104; i++) do_write(AW'(i), $urandom | 32'h1);
    for (int i = 0; i < 6; i++) do_write(AW'($urandom_range(200, DEPTH - 1)), $urandom);
    check("mid_ovr_before", 32'(overrun), 32'(m_ovr));
    pulse_ctrl(C_CLEAR);
    repeat (100) @(posedge clk_clk);
    @(negedge clk_clk);
    reset_reset = 1'b1;
    #1;
    for (int i = 0; i < 100; i++) m_bank[back_bank()][i] = '0;
    m_front = 1'b0;
    m_ovr   = 1'b0;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_front", 32'(front_sel), 32'(m_front));
    check("mid_ovr", 32'(overrun), 32'(m_ovr));
    @(negedge clk_clk);
    reset_reset = 1'b0;
    tick();
    for (int i = 96; i < 104; i++) check_read("mid_partial", AW'(i));
    repeat (20) tick();
    check_read("mid_no_more_100", 11'd100);
    for (int i = 0; i < 12; i++) check_read("mid_rand", AW'($urandom_range(0, DEPTH - 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case something above stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
